// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - MEM-stage load/store unit with sub-word read-modify-write to word-only dmem
// Optional macro MISALIGN_TRAP_EN: suppress misaligned accesses and pulse FAULT instead of aligning down.
module mem_access_unit #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              REQ_VALID,
  input  logic              REQ_WE,
  input  logic [1:0]        REQ_SIZE,
  input  logic              REQ_UNS,
  input  logic [ADDR_W-1:0] ADDR,
  input  logic [DATA_W-1:0] WDATA,
  output logic              STALL,
  output logic [DATA_W-1:0] LOAD_DATA,
  output logic              LOAD_VALID,
  output logic              FAULT,
  output logic [ADDR_W-1:0] MEM_A,
  output logic              MEM_WE,
  output logic [DATA_W-1:0] MEM_WD,
  input  logic [DATA_W-1:0] MEM_RD
);

  typedef enum logic {IDLE, RMW_WR} state_t;

  state_t            state, state_nx;
  logic [DATA_W-1:0] merge_q, merge_nx;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] word_addr;
  logic              is_byte, is_half, is_word;
  logic              suppress, accept, do_load, do_sub_store;
  logic [1:0]        lane;
  logic [4:0]        lane_sh;
  logic [DATA_W-1:0] shifted, load_result;
  logic              we_c;

  assign is_byte   = (REQ_SIZE == 2'b00);
  assign is_half   = (REQ_SIZE == 2'b01);
  assign is_word   = REQ_SIZE[1];
  assign word_addr = {ADDR[ADDR_W-1:2], 2'b00};

`ifdef MISALIGN_TRAP_EN
  logic misaligned;
  logic fault_q;
  assign misaligned = (is_half && ADDR[0]) || (is_word && (ADDR[1:0] != 2'b00));
  assign suppress   = misaligned;
  assign FAULT      = fault_q;
`else
  assign suppress   = 1'b0;
  assign FAULT      = 1'b0;
`endif

  // Offending low bits are dropped by lane selection, so misaligned accesses align down.
  assign lane    = is_byte ? ADDR[1:0] : (is_half ? {ADDR[1], 1'b0} : 2'b00);
  assign lane_sh = {lane, 3'b000};

  assign accept       = (state == IDLE) && REQ_VALID && !suppress;
  assign do_load      = accept && !REQ_WE;
  assign do_sub_store = accept && REQ_WE && !is_word;

  assign shifted = MEM_RD >> lane_sh;

  always_comb begin
    load_result = MEM_RD;
    if (is_byte)
      load_result = {{(DATA_W-8){!REQ_UNS && shifted[7]}}, shifted[7:0]};
    else if (is_half)
      load_result = {{(DATA_W-16){!REQ_UNS && shifted[15]}}, shifted[15:0]};
  end

  always_comb begin
    merge_nx = MEM_RD;
    if (is_byte)
      merge_nx[lane_sh +: 8] = WDATA[7:0];
    else
      merge_nx[lane_sh +: 16] = WDATA[15:0];
  end

  always_comb begin
    state_nx = state;
    STALL    = 1'b0;
    we_c     = 1'b0;
    MEM_A    = word_addr;
    MEM_WD   = WDATA;
    case (state)
      IDLE: begin
        if (accept && REQ_WE) begin
          if (is_word) begin
            we_c = 1'b1;
          end else begin
            STALL    = 1'b1;
            state_nx = RMW_WR;
          end
        end
      end
      RMW_WR: begin
        MEM_A    = addr_q;
        MEM_WD   = merge_q;
        we_c     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Gate with reset so an asserted reset kills the write without waiting for a clock edge.
  assign MEM_WE = we_c && RST_N;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state      <= IDLE;
      merge_q    <= '0;
      addr_q     <= '0;
      LOAD_DATA  <= '0;
      LOAD_VALID <= 1'b0;
    end else begin
      state      <= state_nx;
      LOAD_VALID <= do_load;
      if (do_load)
        LOAD_DATA <= load_result;
      if (do_sub_store) begin
        merge_q <= merge_nx;
        addr_q  <= word_addr;
      end
    end
  end

`ifdef MISALIGN_TRAP_EN
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)
      fault_q <= 1'b0;
    else
      fault_q <= (state == IDLE) && REQ_VALID && misaligned;
  end
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - scoreboard bench for mem_access_unit against a byte-addressed memory model
module tb_mem_access_unit;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        REQ_VALID, REQ_WE, REQ_UNS;
  logic [1:0]  REQ_SIZE;
  logic [31:0] ADDR, WDATA;
  logic        STALL, LOAD_VALID, FAULT, MEM_WE;
  logic [31:0] LOAD_DATA, MEM_A, MEM_WD, MEM_RD;

  logic [31:0] dmem [0:63];
  logic [7:0]  rb [0:255];

  logic [31:0] wq_a[$];
  logic [31:0] wq_d[$];
  logic [31:0] lq[$];
  int          exp_faults = 0;
  int          n_vec = 0;
  int          n_fail = 0;

  mem_access_unit #(.DATA_W(32), .ADDR_W(32)) dut (
    .CLK(CLK), .RST_N(RST_N), .REQ_VALID(REQ_VALID), .REQ_WE(REQ_WE),
    .REQ_SIZE(REQ_SIZE), .REQ_UNS(REQ_UNS), .ADDR(ADDR), .WDATA(WDATA),
    .STALL(STALL), .LOAD_DATA(LOAD_DATA), .LOAD_VALID(LOAD_VALID), .FAULT(FAULT),
    .MEM_A(MEM_A), .MEM_WE(MEM_WE), .MEM_WD(MEM_WD), .MEM_RD(MEM_RD)
  );

  always #5 CLK = ~CLK;

  assign MEM_RD = dmem[MEM_A[7:2]];
  always @(posedge CLK) if (MEM_WE) dmem[MEM_A[7:2]] <= MEM_WD;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int nbytes(input logic [1:0] s);
    return (s == 2'b00) ? 1 : ((s == 2'b01) ? 2 : 4);
  endfunction

  function automatic logic [31:0] ref_word(input logic [5:0] w);
    logic [31:0] v;
    for (int i = 0; i < 4; i++) v[8*i +: 8] = rb[{w, 2'b00} + i];
    return v;
  endfunction

  // Monitor: pops expectations whenever the DUT presents a write, a load result or a fault.
  always @(negedge CLK) begin
    if (RST_N) begin
      if (MEM_WE) begin
        if (wq_a.size() == 0) begin
          n_vec++; n_fail++;
          $display("FAIL unexpected_write: got addr %h data %h expected no write", MEM_A, MEM_WD);
        end else begin
          chk("mem_a", MEM_A, wq_a.pop_front());
          chk("mem_wd", MEM_WD, wq_d.pop_front());
        end
      end
      if (LOAD_VALID) begin
        if (lq.size() == 0) begin
          n_vec++; n_fail++;
          $display("FAIL unexpected_load_valid: got data %h expected no load", LOAD_DATA);
        end else begin
          chk("load_data", LOAD_DATA, lq.pop_front());
        end
      end
      if (FAULT) begin
        if (exp_faults == 0) begin
          n_vec++; n_fail++;
          $display("FAIL unexpected_fault: got 1 expected 0");
        end else begin
          exp_faults--;
          n_vec++;
        end
      end
    end
  end

  task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                       input logic [7:0] addr, input logic [31:0] wd);
    int          n;
    logic [7:0]  a;
    logic        mis;
    logic        stall_e;
    logic [31:0] v;
    n       = nbytes(size);
    mis     = (n == 2 && addr[0]) || (n == 4 && addr[1:0] != 2'b00);
    a       = addr & ~8'(n - 1);
    stall_e = 1'b0;
`ifdef MISALIGN_TRAP_EN
    if (mis) exp_faults++;
    else
`endif
    begin
      if (we) begin
        for (int i = 0; i < n; i++) rb[a + i] = wd[8*i +: 8];
        wq_a.push_back({24'h0, a[7:2], 2'b00});
        wq_d.push_back(ref_word(a[7:2]));
        stall_e = (n != 4);
      end else begin
        v = '0;
        for (int i = 0; i < n; i++) v[8*i +: 8] = rb[a + i];
        if (!uns && n < 4 && v[8*n-1])
          for (int i = n; i < 4; i++) v[8*i +: 8] = 8'hFF;
        lq.push_back(v);
      end
    end
    REQ_VALID = 1'b1; REQ_WE = we; REQ_SIZE = size; REQ_UNS = uns;
    ADDR = {24'h0, addr}; WDATA = wd;
    @(negedge CLK);
    chk("stall", {31'h0, STALL}, {31'h0, stall_e});
    @(posedge CLK); #1;
    if (stall_e) begin
      @(negedge CLK);
      chk("stall_rmw", {31'h0, STALL}, 32'h0);
      @(posedge CLK); #1;
    end
    REQ_VALID = 1'b0;
  endtask

  task automatic idle(input int n);
    REQ_VALID = 1'b0;
    repeat (n) begin @(posedge CLK); #1; end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    RST_N = 1'b0; REQ_VALID = 1'b0; REQ_WE = 1'b0; REQ_SIZE = 2'b00;
    REQ_UNS = 1'b0; ADDR = '0; WDATA = '0;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_load_data", LOAD_DATA, 32'h0);
    chk("rst_load_valid", {31'h0, LOAD_VALID}, 32'h0);
    chk("rst_fault", {31'h0, FAULT}, 32'h0);
    chk("rst_mem_we", {31'h0, MEM_WE}, 32'h0);
    chk("rst_stall", {31'h0, STALL}, 32'h0);
    @(negedge CLK); RST_N = 1'b1;
    @(posedge CLK); #1;

    for (int w = 0; w < 64; w++) issue(1'b1, 2'b10, 1'b0, 8'(w * 4), $urandom);

    // Word store then word load
    issue(1'b1, 2'b10, 1'b0, 8'd0, 32'd10);
    issue(1'b0, 2'b10, 1'b0, 8'd0, 32'h0);
    idle(2);
    // Byte RMW into a known word
    issue(1'b1, 2'b10, 1'b0, 8'd252, 32'h11223344);
    issue(1'b1, 2'b00, 1'b0, 8'd253, 32'h000000AB);
    idle(1);
    // Sign/zero extension
    issue(1'b1, 2'b10, 1'b0, 8'd252, 32'h80FF7F01);
    issue(1'b0, 2'b00, 1'b0, 8'd255, 32'h0);
    issue(1'b0, 2'b00, 1'b1, 8'd255, 32'h0);
    issue(1'b0, 2'b01, 1'b0, 8'd254, 32'h0);
    issue(1'b0, 2'b01, 1'b1, 8'd252, 32'h0);
    // Misaligned word load
    issue(1'b0, 2'b10, 1'b0, 8'd2, 32'h0);
    idle(3);

    // Reset during the RMW write cycle drops the write
    REQ_VALID = 1'b1; REQ_WE = 1'b1; REQ_SIZE = 2'b01; REQ_UNS = 1'b0;
    ADDR = 32'd252; WDATA = 32'h0000BEEF;
    @(negedge CLK);
    chk("rmw_stall", {31'h0, STALL}, 32'h1);
    @(posedge CLK); #2;
    RST_N = 1'b0;
    #1;
    chk("rmw_rst_mem_we", {31'h0, MEM_WE}, 32'h0);
    chk("rmw_rst_load_data", LOAD_DATA, 32'h0);
    chk("rmw_rst_load_valid", {31'h0, LOAD_VALID}, 32'h0);
    chk("rmw_rst_fault", {31'h0, FAULT}, 32'h0);
    REQ_VALID = 1'b0;
    @(negedge CLK);
    chk("rmw_rst_mem_we_hold", {31'h0, MEM_WE}, 32'h0);
    RST_N = 1'b1;
    @(posedge CLK); #1;
    issue(1'b0, 2'b10, 1'b0, 8'd252, 32'h0);

    // Back-to-back SB, LW, SW
    issue(1'b1, 2'b00, 1'b0, 8'd0, 32'h0000005A);
    issue(1'b0, 2'b10, 1'b0, 8'd0, 32'h0);
    issue(1'b1, 2'b10, 1'b0, 8'd4, 32'hCAFEF00D);
    idle(2);

    for (int k = 0; k < 400; k++) begin
      issue(1'($urandom), 2'($urandom), 1'($urandom), 8'($urandom_range(0, 255)), $urandom);
      if ($urandom_range(0, 4) == 0) idle($urandom_range(1, 2));
    end
    idle(4);

    chk("writes_drained", wq_a.size(), 32'h0);
    chk("loads_drained", lq.size(), 32'h0);
    chk("faults_drained", exp_faults, 32'h0);
    for (int w = 0; w < 64; w++) chk("final_mem", dmem[w], ref_word(6'(w)));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
